// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the master requests an
// addition, the slave (the adder) reports busy/done and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, result shifted into sum
// from the MSB end; done pulses once WIDTH+1 cycles after start is accepted.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             cout_q;
  logic             last_bit;
  logic             busy_c;
  logic             done_c;

  logic a_i;
  logic b_i;
  logic hs1_sum;
  logic hs1_carry;
  logic sum_bit;
  logic hs2_carry;
  logic carry_next;

  // Full adder as two cascaded half adders plus an OR of their carries
  assign a_i        = a_sh[0];
  assign b_i        = b_sh[0];
  assign hs1_sum    = a_i ^ b_i;
  assign hs1_carry  = a_i & b_i;
  assign sum_bit    = hs1_sum ^ carry;
  assign hs2_carry  = hs1_sum & carry;
  assign carry_next = hs1_carry | hs2_carry;

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operands are only captured in IDLE, so start during RUN/DONE cannot disturb them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      cout_q  <= 1'b0;
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        a_sh    <= bus.a;
        b_sh    <= bus.b;
        carry   <= bus.cin;
        bit_cnt <= '0;
      end
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= {sum_bit, sum_sh[WIDTH-1:1]};
      carry   <= carry_next;
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (last_bit) begin
        cout_q <= carry_next;
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.sum  = sum_sh;
  assign bus.cout = cout_q;

endmodule
